// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and bit-vector helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

  // Helpers work on a fixed-width vector; callers truncate to their N_REQ (<= ARB_MAX_N).
  localparam int unsigned ARB_MAX_N = 32;
  typedef logic [ARB_MAX_N-1:0] arb_vec_t;

  function automatic arb_vec_t onehot(input int unsigned idx, input int unsigned n);
    arb_vec_t v;
    v = '0;
    if (idx < n) begin
      v = arb_vec_t'(1) << idx;
    end
    return v;
  endfunction

  // Bits strictly below idx: the requesters that outrank the previous owner.
  function automatic arb_vec_t low_mask(input int unsigned idx);
    return (arb_vec_t'(1) << idx) - arb_vec_t'(1);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if #(
  parameter int unsigned N_REQ = 8
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             preempt;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output preempt
  );

endinterface

// File: rtl/rr_grant_arbiter_prio_enc.sv
// Combinational MSB-first priority encoder: index of the highest set bit plus a valid flag.
module prio_enc_msb #(
  parameter int unsigned IN_WIDTH = 8,
  localparam int unsigned OUT_W = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] in_vec,
  output logic [OUT_W-1:0]    idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = |in_vec;
    // Ascending scan, so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (in_vec[i]) begin
        idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: grants held until the owner drops req or a hold timeout rotates it.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HC_W-1:0] HOLD_SAT  = '1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             preempt_q, preempt_d;

  logic [ID_W-1:0]  mask_id;
  logic [N_REQ-1:0] cand_lo;
  logic [ID_W-1:0]  lo_idx, all_idx, winner;
  logic             lo_vld, all_vld;
  logic             drop, to;

  // While granting, a release re-arbitrates against the current owner in the same cycle.
  assign mask_id = (state_q == ARB_GRANT) ? gnt_id_q : last_id_q;
  assign cand_lo = bus.req & N_REQ'(low_mask(32'(mask_id)));

  prio_enc_msb #(.IN_WIDTH(N_REQ)) u_enc_lo (
    .in_vec (cand_lo),
    .idx    (lo_idx),
    .valid  (lo_vld)
  );

  prio_enc_msb #(.IN_WIDTH(N_REQ)) u_enc_all (
    .in_vec (bus.req),
    .idx    (all_idx),
    .valid  (all_vld)
  );

  assign winner = lo_vld ? lo_idx : all_idx;
  assign drop   = !bus.req[gnt_id_q];
  assign to     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (all_vld) begin
          state_d    = ARB_GRANT;
          gnt_d      = N_REQ'(onehot(32'(winner), N_REQ));
          gnt_id_d   = winner;
          hold_cnt_d = '0;
        end
      end

      ARB_GRANT: begin
        if (drop || to) begin
          last_id_d  = gnt_id_q;
          preempt_d  = to && !drop;
          hold_cnt_d = '0;
          if (all_vld) begin
            gnt_d    = N_REQ'(onehot(32'(winner), N_REQ));
            gnt_id_d = winner;
          end else begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end

      default: begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N_REQ=8, MAX_HOLD=4); outputs sampled on falling edges.
module tb_rr_grant_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rr_grant_arbiter_if #(.N_REQ(N)) bus ();

  rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset[%0d]: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=00 id=0 valid=0 preempt=0",
                 i, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
      end else $display("reset[%0d]: gnt=%h id=%0d ok", i, bus.gnt, bus.gnt_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=80 id=7 valid=1 preempt=0",
               bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
    end else $display("reset_release: gnt=%h id=%0d ok", bus.gnt, bus.gnt_id);
  endtask

  task automatic test_rotation();
    int          order [4] = '{7, 0, 7, 0};
    logic [2:0]  eid;
    logic [7:0]  egnt;
    do_reset();
    bus.req = 8'h81;
    for (int k = 0; k < 4; k++) begin
      eid  = 3'(order[k]);
      egnt = 8'h01 << eid;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++;
        if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {egnt, eid, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rotation[%0d.%0d]: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=%h id=%0d valid=1 preempt=0",
                   k, c, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt, egnt, eid);
        end else $display("rotation[%0d.%0d]: gnt_id=%0d ok", k, c, bus.gnt_id);
        // Owner re-raises in its first cycle, drops after its second.
        bus.req = (c == 0) ? 8'h81 : (8'h81 & ~egnt);
      end
    end
  endtask

  task automatic test_timeout();
    int          exp_id [9] = '{5, 5, 5, 5, 2, 2, 2, 2, 5};
    logic        exp_pe [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [2:0]  eid;
    logic [7:0]  egnt;
    do_reset();
    bus.req = 8'h24;
    for (int i = 0; i < 9; i++) begin
      eid  = 3'(exp_id[i]);
      egnt = 8'h01 << eid;
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {egnt, eid, 1'b1, exp_pe[i]}) begin
        errors++;
        $display("FAIL timeout[%0d]: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=%h id=%0d valid=1 preempt=%b",
                 i, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt, egnt, eid, exp_pe[i]);
      end else $display("timeout[%0d]: gnt_id=%0d preempt=%b ok", i, bus.gnt_id, bus.preempt);
    end
  endtask

  task automatic test_sole_timeout();
    logic epe;
    do_reset();
    bus.req = 8'h08;
    for (int i = 0; i < 13; i++) begin
      epe = (i != 0) && (i % 4 == 0);
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h08, 3'd3, 1'b1, epe}) begin
        errors++;
        $display("FAIL sole[%0d]: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=08 id=3 valid=1 preempt=%b",
                 i, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt, epe);
      end else $display("sole[%0d]: gnt_id=%0d preempt=%b ok", i, bus.gnt_id, bus.preempt);
    end
  endtask

  task automatic test_drop_new();
    do_reset();
    bus.req = 8'h20;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL drop_new_owner: gnt=%h id=%0d valid=%b, expected gnt=20 id=5 valid=1",
               bus.gnt, bus.gnt_id, bus.gnt_valid);
    end else $display("drop_new_owner: gnt_id=%0d ok", bus.gnt_id);
    bus.req = 8'h02;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drop_new_switch: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=02 id=1 valid=1 preempt=0",
               bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
    end else $display("drop_new_switch: gnt_id=%0d ok", bus.gnt_id);
    bus.req = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL drop_idle[%0d]: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=00 id=0 valid=0 preempt=0",
                 i, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
      end else $display("drop_idle[%0d]: gnt=%h ok", i, bus.gnt);
    end
  endtask

  task automatic test_drop_with_timeout();
    do_reset();
    bus.req = 8'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.gnt_id, bus.preempt} !== {8'h20, 3'd5, 1'b0}) begin
        errors++;
        $display("FAIL drop_to_hold[%0d]: gnt=%h id=%0d preempt=%b, expected gnt=20 id=5 preempt=0",
                 i, bus.gnt, bus.gnt_id, bus.preempt);
      end else $display("drop_to_hold[%0d]: gnt_id=%0d ok", i, bus.gnt_id);
    end
    // Owner drops in the very cycle its hold count expires.
    bus.req = 8'h02;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL drop_to_release: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=02 id=1 valid=1 preempt=0",
               bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
    end else $display("drop_to_release: gnt_id=%0d preempt=%b ok", bus.gnt_id, bus.preempt);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 8'h04;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id} !== {8'h04, 3'd2}) begin
      errors++;
      $display("FAIL mid_first: gnt=%h id=%0d, expected gnt=04 id=2", bus.gnt, bus.gnt_id);
    end else $display("mid_first: gnt_id=%0d ok", bus.gnt_id);
    bus.req = 8'h08;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id} !== {8'h08, 3'd3}) begin
      errors++;
      $display("FAIL mid_second: gnt=%h id=%0d, expected gnt=08 id=3", bus.gnt, bus.gnt_id);
    end else $display("mid_second: gnt_id=%0d ok", bus.gnt_id);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: gnt=%h id=%0d valid=%b preempt=%b, expected gnt=00 id=0 valid=0 preempt=0",
               bus.gnt, bus.gnt_id, bus.gnt_valid, bus.preempt);
    end else $display("mid_reset: gnt=%h ok", bus.gnt);
    rst_n   = 1'b1;
    bus.req = 8'h06;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_after: gnt=%h id=%0d valid=%b, expected gnt=04 id=2 valid=1",
               bus.gnt, bus.gnt_id, bus.gnt_valid);
    end else $display("mid_after: gnt_id=%0d ok", bus.gnt_id);
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_rotation();
    test_timeout();
    test_sole_timeout();
    test_drop_new();
    test_drop_with_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
